// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the APB3 slave controller.
package apb_slave_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slv_state_e;

    // Counter width that can hold 0..n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_slave_wait_cnt.sv
// Wait-state counter: clearable, enabled, saturating at WAIT_CYCLES with a done flag.
module apb_slave_wait_cnt
    import apb_slave_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic done
);

    localparam int CW = cnt_width(WAIT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_CYCLES);

    logic [CW-1:0] cnt;

    // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = (cnt == LIMIT);

endmodule

// File: rtl/apb_slave_ctrl.sv
// APB3 slave protocol controller in front of a word RAM, with configurable wait states.
// Define APB_SLAVE_CTRL_ADDR_WRAP_EN to wrap out-of-range addresses modulo DEPTH instead of erroring.
module apb_slave_ctrl
    import apb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    apb_slv_state_e        state_q, state_d;
    logic                  write_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic setup;
    logic addr_err;
    logic cnt_clear;
    logic cnt_en;
    logic cnt_done;

    assign setup = PSEL && !PENABLE;

`ifdef APB_SLAVE_CTRL_ADDR_WRAP_EN
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    assign addr_err = 1'b0;
    assign ram_addr = {{(ADDR_WIDTH - IDX_W){1'b0}}, addr_q[IDX_W-1:0]};
`else
    assign addr_err = (PADDR >= ADDR_WIDTH'(DEPTH));
    assign ram_addr = addr_q;
`endif

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && setup) begin
                write_q <= PWRITE;
                err_q   <= addr_err;
                addr_q  <= PADDR;
                wdata_q <= PWDATA;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_clear = 1'b1;
                if (setup) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!PSEL || cnt_done) begin
                    state_d = IDLE;
                end else begin
                    cnt_en = PENABLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    apb_slave_wait_cnt #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_cnt (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .clear (cnt_clear),
        .en    (cnt_en),
        .done  (cnt_done)
    );

    // A dropped PSEL means the master abandoned the transfer, so it can never complete.
    assign PREADY    = PRESETn && (state_q == ACCESS) && PSEL && cnt_done;
    assign PSLVERR   = PREADY && err_q;
    assign ram_en    = PREADY && write_q && !err_q;
    assign PRDATA    = (PREADY && !write_q && !err_q) ? ram_rdata : '0;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_apb_slave_ctrl.sv
// Directed bench: three controllers (0, 2 and 3 wait states), each fronting a small RAM model.
module tb_apb_slave_ctrl;

    logic        clk = 1'b0;
    logic        presetn [3];
    logic        psel    [3];
    logic        penable [3];
    logic        pwrite  [3];
    logic [31:0] paddr   [3];
    logic [31:0] pwdata  [3];
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];
    logic        ram_en  [3];
    logic [31:0] ram_addr  [3];
    logic [31:0] ram_wdata [3];
    logic [31:0] ram_rdata [3];

    logic [31:0] mem [3][16];
    int          en_cnt [3] = '{0, 0, 0};
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    apb_slave_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (
        .PCLK(clk), .PRESETn(presetn[0]), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]),
        .PREADY(pready[0]), .PSLVERR(pslverr[0]), .ram_en(ram_en[0]),
        .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]));

    apb_slave_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(2)) u_dut1 (
        .PCLK(clk), .PRESETn(presetn[1]), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]),
        .PREADY(pready[1]), .PSLVERR(pslverr[1]), .ram_en(ram_en[1]),
        .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]));

    apb_slave_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(3)) u_dut2 (
        .PCLK(clk), .PRESETn(presetn[2]), .PSEL(psel[2]), .PENABLE(penable[2]),
        .PWRITE(pwrite[2]), .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PRDATA(prdata[2]),
        .PREADY(pready[2]), .PSLVERR(pslverr[2]), .ram_en(ram_en[2]),
        .ram_addr(ram_addr[2]), .ram_wdata(ram_wdata[2]), .ram_rdata(ram_rdata[2]));

    // RAM models: write on the strobe, combinational read at the presented address.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ram_en[k]) begin
                mem[k][ram_addr[k][3:0]] <= ram_wdata[k];
                en_cnt[k] <= en_cnt[k] + 1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            ram_rdata[k] = mem[k][ram_addr[k][3:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transfer on controller k; inputs are driven 1 time unit after the rising edge
    // and outputs sampled on the falling edge.
    task automatic apb_xfer(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input int waits, input logic exp_err, input logic [31:0] exp_rd,
                            input string tag);
        int e0;
        e0 = en_cnt[k];
        psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = a; pwdata[k] = d;
        @(negedge clk);
        check({tag, " setup pready"}, 32'(pready[k]), 32'd0);
        @(posedge clk); #1;
        penable[k] = 1'b1;
        for (int n = 0; n < waits; n++) begin
            @(negedge clk);
            check($sformatf("%s wait%0d pready", tag, n), 32'(pready[k]), 32'd0);
            check($sformatf("%s wait%0d ram_en", tag, n), 32'(ram_en[k]), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check({tag, " pready"}, 32'(pready[k]), 32'd1);
        check({tag, " pslverr"}, 32'(pslverr[k]), 32'(exp_err));
        check({tag, " ram_en"}, 32'(ram_en[k]), 32'(wr && !exp_err));
        if (!wr) check({tag, " prdata"}, prdata[k], exp_rd);
        @(posedge clk); #1;
        psel[k] = 1'b0; penable[k] = 1'b0;
        check({tag, " ram_en pulses"}, 32'(en_cnt[k] - e0), 32'(wr && !exp_err));
    endtask

    initial begin
        int e0;
        logic        oob_err;
        logic [31:0] oob_rd;
        logic [31:0] word0_rd;
`ifdef APB_SLAVE_CTRL_ADDR_WRAP_EN
        oob_err = 1'b0; oob_rd = 32'hAAAA_5555; word0_rd = 32'hAAAA_5555;
`else
        oob_err = 1'b1; oob_rd = 32'h0;         word0_rd = 32'h0000_0C0C;
`endif
        for (int k = 0; k < 3; k++) begin
            presetn[k] = 1'b0; psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
            paddr[k] = '0; pwdata[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst%0d pready", k), 32'(pready[k]), 32'd0);
            check($sformatf("rst%0d pslverr", k), 32'(pslverr[k]), 32'd0);
            check($sformatf("rst%0d ram_en", k), 32'(ram_en[k]), 32'd0);
            check($sformatf("rst%0d prdata", k), prdata[k], 32'd0);
            check($sformatf("rst%0d ram_addr", k), ram_addr[k], 32'd0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) presetn[k] = 1'b1;
        @(posedge clk); #1;

        // Zero-wait write then read.
        apb_xfer(0, 1'b1, 32'd3, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, "w0 wr3");
        apb_xfer(0, 1'b0, 32'd3, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, "w0 rd3");

        // Two wait states at the top legal address.
        apb_xfer(1, 1'b1, 32'd15, 32'h1234_5678, 2, 1'b0, 32'h0, "w2 wr15");
        apb_xfer(1, 1'b0, 32'd15, 32'h0, 2, 1'b0, 32'h1234_5678, "w2 rd15");

        // First out-of-range address; word 0 shows whether a wrapped write landed there.
        apb_xfer(0, 1'b1, 32'd0, 32'h0000_0C0C, 0, 1'b0, 32'h0, "w0 wr0");
        apb_xfer(0, 1'b1, 32'd16, 32'hAAAA_5555, 0, oob_err, 32'h0, "w0 wr16");
        apb_xfer(0, 1'b0, 32'd16, 32'h0, 0, oob_err, oob_rd, "w0 rd16");
        apb_xfer(0, 1'b0, 32'd0, 32'h0, 0, 1'b0, word0_rd, "w0 rd0");

        // Back-to-back transfers with no idle cycles, on both the 0- and 2-wait controllers.
        for (int k = 0; k < 2; k++) begin
            int w;
            w = 2 * k;
            apb_xfer(k, 1'b1, 32'd1, 32'hA, w, 1'b0, 32'h0, $sformatf("b2b%0d wr1", k));
            apb_xfer(k, 1'b1, 32'd2, 32'hB, w, 1'b0, 32'h0, $sformatf("b2b%0d wr2", k));
            apb_xfer(k, 1'b0, 32'd1, 32'h0, w, 1'b0, 32'hA, $sformatf("b2b%0d rd1", k));
            apb_xfer(k, 1'b0, 32'd2, 32'h0, w, 1'b0, 32'hB, $sformatf("b2b%0d rd2", k));
        end
        @(posedge clk); #1;

        // Abort: PSEL dropped after one access cycle of a write.
        apb_xfer(2, 1'b1, 32'd5, 32'h0000_0055, 3, 1'b0, 32'h0, "abort pre wr5");
        e0 = en_cnt[2];
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'd5; pwdata[2] = 32'h99;
        @(posedge clk); #1;
        penable[2] = 1'b1;
        @(negedge clk);
        check("abort acc pready", 32'(pready[2]), 32'd0);
        @(posedge clk); #1;
        psel[2] = 1'b0; penable[2] = 1'b0;
        @(negedge clk);
        check("abort drop pready", 32'(pready[2]), 32'd0);
        check("abort drop ram_en", 32'(ram_en[2]), 32'd0);
        @(posedge clk); #1;
        check("abort ram_en pulses", 32'(en_cnt[2] - e0), 32'd0);
        apb_xfer(2, 1'b0, 32'd5, 32'h0, 3, 1'b0, 32'h0000_0055, "abort rd5");

        // Reset pulse in the middle of a two-wait write.
        apb_xfer(1, 1'b1, 32'd7, 32'h0000_0070, 2, 1'b0, 32'h0, "rstmid pre wr7");
        e0 = en_cnt[1];
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'd7; pwdata[1] = 32'h77;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        presetn[1] = 1'b0;
        @(posedge clk); #1;
        presetn[1] = 1'b1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge clk);
        check("rstmid pready", 32'(pready[1]), 32'd0);
        check("rstmid pslverr", 32'(pslverr[1]), 32'd0);
        check("rstmid ram_en", 32'(ram_en[1]), 32'd0);
        check("rstmid prdata", prdata[1], 32'd0);
        check("rstmid ram_addr", ram_addr[1], 32'd0);
        check("rstmid ram_wdata", ram_wdata[1], 32'd0);
        @(posedge clk); #1;
        check("rstmid ram_en pulses", 32'(en_cnt[1] - e0), 32'd0);
        apb_xfer(1, 1'b0, 32'd7, 32'h0, 2, 1'b0, 32'h0000_0070, "rstmid rd7");
        apb_xfer(1, 1'b1, 32'd9, 32'h0000_0909, 2, 1'b0, 32'h0, "rstmid wr9");
        apb_xfer(1, 1'b0, 32'd9, 32'h0, 2, 1'b0, 32'h0000_0909, "rstmid rd9");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
